// File: rtl/apb_arb_pkg.sv
// Shared types and address map for the APB request arbiter.
// Covers the FSM state encoding and the legal register addresses of the control slave.
package apb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    CAPT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int unsigned CHK_AW = 64;

  localparam logic [CHK_AW-1:0] ADDR_CNTRL = 64'h0;
  localparam logic [CHK_AW-1:0] ADDR_REG1  = 64'h4;
  localparam logic [CHK_AW-1:0] ADDR_REG2  = 64'h8;
  localparam logic [CHK_AW-1:0] ADDR_REG3  = 64'hC;
  localparam logic [CHK_AW-1:0] ADDR_REG4  = 64'h10;

  // True only for the five word-aligned registers of the slave.
  function automatic logic addr_legal(input logic [CHK_AW-1:0] addr);
    return (addr == ADDR_CNTRL) || (addr == ADDR_REG1) || (addr == ADDR_REG2) ||
           (addr == ADDR_REG3)  || (addr == ADDR_REG4);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the last-grant pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_gnt_idx,
  output logic            o_any
);

  int unsigned w_dist;
  int unsigned w_best;

  // Distance of requester i from the pointer; the smallest nonzero step wins.
  always_comb begin
    w_dist    = 0;
    w_best    = NREQ;
    o_gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_req[i]) begin
        w_dist = i + NREQ - 1 - 32'(i_ptr);
        if (w_dist >= NREQ) begin
          w_dist = w_dist - NREQ;
        end
        if (w_dist < w_best) begin
          w_best    = w_dist;
          o_gnt_idx = IW'(i);
        end
      end
    end
  end

  assign o_any = |i_req;
  assign o_gnt = o_any ? (NREQ'(1) << o_gnt_idx) : '0;

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB register slave among NREQ requesters with round-robin arbitration.
// Slave has no pready and registers its read data, so reads take an extra capture cycle.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  input  logic [DW-1:0]    prdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_rsp_err;
  logic            r_busy;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;
  logic            w_sel_write;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_legal;
  logic            w_grant;

  logic [IW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic            w_psel_nxt;
  logic            w_penable_nxt;
  logic            w_pwrite_nxt;
  logic [AW-1:0]   w_paddr_nxt;
  logic [DW-1:0]   w_pwdata_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic [DW-1:0]   w_rsp_rdata_nxt;
  logic            w_rsp_err_nxt;
  logic            w_busy_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Mux the winning requester's payload.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_addr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign w_sel_legal = addr_legal(CHK_AW'(w_sel_addr));
  assign w_grant     = (r_state == IDLE) && w_any;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = w_sel_legal ? SETUP : RESP;
        end
      end
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = r_pwrite ? RESP : CAPT;
      CAPT:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_psel_nxt      = 1'b0;
    w_penable_nxt   = 1'b0;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_done_nxt      = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_busy_nxt      = (w_state_nxt != IDLE);

    w_psel_nxt    = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
    w_penable_nxt = (w_state_nxt == ACCESS);

    if (w_grant) begin
      w_ptr_nxt       = w_gnt_idx;
      w_gnt_nxt       = w_gnt;
      w_rsp_rdata_nxt = '0;
      w_rsp_err_nxt   = !w_sel_legal;
      if (w_sel_legal) begin
        w_pwrite_nxt = w_sel_write;
        w_paddr_nxt  = w_sel_addr;
        w_pwdata_nxt = w_sel_wdata;
      end
    end

    if (r_state == CAPT) begin
      w_rsp_rdata_nxt = prdata;
    end

    if (w_state_nxt == RESP) begin
      w_done_nxt = (r_state == IDLE) ? w_gnt : r_gnt;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ptr       <= IW'(NREQ - 1);
      r_gnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_done      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_done      <= w_done_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign done      = r_done;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;

endmodule
